oric_ram_arbiter: RTL and testbench



---
 rtl/oric_ram_arbiter_if.sv | 44 ++++
 rtl/oric_ram_arbiter.sv | 152 +++++++++++++++
 tb/tb_oric_ram_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/oric_ram_arbiter_if.sv
// Bus bundle between the Oric RAM arbiter and its requesters / RAM array.
// The arbiter takes the slave side; CPU, tape loader and RAM model sit on master.
interface oric_ram_arbiter_if #(
    parameter int AW = 16
);
    logic          clr_start;
    logic          clr_busy;

    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_wait;
    logic          cpu_rvalid;
    logic [7:0]    cpu_dout;

    logic          tape_wr;
    logic [AW-1:0] tape_addr;
    logic [7:0]    tape_din;
    logic          tape_wait;
    logic          tape_ovf;
    logic [AW:0]   tape_count;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_din;
    logic [7:0]    mem_q;

    modport slave (
        input  clr_start, cpu_cs, cpu_we, cpu_addr, cpu_din,
        input  tape_wr, tape_addr, tape_din, mem_q,
        output clr_busy, cpu_wait, cpu_rvalid, cpu_dout,
        output tape_wait, tape_ovf, tape_count,
        output mem_addr, mem_we, mem_din
    );

    modport master (
        output clr_start, cpu_cs, cpu_we, cpu_addr, cpu_din,
        output tape_wr, tape_addr, tape_din, mem_q,
        input  clr_busy, cpu_wait, cpu_rvalid, cpu_dout,
        input  tape_wait, tape_ovf, tape_count,
        input  mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/oric_ram_arbiter.sv
// Single-port Oric main-RAM arbiter: clear engine, CPU/ULA bus and a one-entry
// tape write buffer with starvation protection share one synchronous RAM port.
module oric_ram_arbiter #(
    parameter int         AW           = 16,
    parameter logic [7:0] CLR_VAL      = 8'hFF,
    parameter bit         CLR_ON_RESET = 1'b1,
    parameter int         STARVE       = 4
) (
    input logic               clk,
    input logic               reset_n,
    oric_ram_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
    localparam logic [SW-1:0] STARVE_ONE = 1;
    localparam logic [AW-1:0] PTR_LAST   = '1;
    localparam logic [AW-1:0] PTR_ONE    = 1;
    localparam logic [AW:0]   CNT_MAX    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE    = 1;

    typedef enum logic {ST_CLEAR, ST_ARB} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          buf_vld_q, buf_vld_d;
    logic [AW-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]    buf_data_q, buf_data_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          tape_ovf_q, tape_ovf_d;
    logic [AW:0]   tape_count_q, tape_count_d;
    logic [1:0]    rd_pipe_q, rd_pipe_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic          force_tape;
    logic          cpu_grant;
    logic          tape_grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CLR_ON_RESET ? ST_CLEAR : ST_ARB;
            clr_ptr_q    <= '0;
            buf_vld_q    <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            starve_q     <= '0;
            tape_ovf_q   <= 1'b0;
            tape_count_q <= '0;
            rd_pipe_q    <= '0;
            cpu_dout_q   <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            buf_vld_q    <= buf_vld_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            starve_q     <= starve_d;
            tape_ovf_q   <= tape_ovf_d;
            tape_count_q <= tape_count_d;
            rd_pipe_q    <= rd_pipe_d;
            cpu_dout_q   <= cpu_dout_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // clr_start restarts the walk from 0 even mid-clear.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (bus.clr_start) begin
            state_d   = ST_CLEAR;
            clr_ptr_d = '0;
        end else if (state_q == ST_CLEAR) begin
            if (clr_ptr_q == PTR_LAST) begin
                state_d   = ST_ARB;
                clr_ptr_d = '0;
            end else begin
                clr_ptr_d = clr_ptr_q + PTR_ONE;
            end
        end
    end

    always_comb begin
        force_tape  = 1'b0;
        cpu_grant   = 1'b0;
        tape_grant  = 1'b0;
        mem_addr_d  = mem_addr_q;
        bus.mem_we  = 1'b0;
        bus.mem_din = '0;
        if (state_q == ST_CLEAR) begin
            mem_addr_d  = clr_ptr_q;
            bus.mem_we  = 1'b1;
            bus.mem_din = CLR_VAL;
        end else begin
            force_tape = buf_vld_q && (starve_q == STARVE_MAX);
            if (force_tape)      tape_grant = 1'b1;
            else if (bus.cpu_cs) cpu_grant  = 1'b1;
            else if (buf_vld_q)  tape_grant = 1'b1;

            if (tape_grant) begin
                mem_addr_d  = buf_addr_q;
                bus.mem_we  = 1'b1;
                bus.mem_din = buf_data_q;
            end else if (cpu_grant) begin
                mem_addr_d  = bus.cpu_addr;
                bus.mem_we  = bus.cpu_we;
                bus.mem_din = bus.cpu_din;
            end
        end
        bus.mem_addr = mem_addr_d;
    end

    // A commit frees the buffer on the same edge, so a concurrent tape_wr still loads.
    always_comb begin
        buf_vld_d    = buf_vld_q & ~tape_grant;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;
        tape_ovf_d   = tape_ovf_q;
        tape_count_d = tape_count_q;
        starve_d     = starve_q;
        if (bus.tape_wr) begin
            if (!buf_vld_q || tape_grant) begin
                buf_vld_d  = 1'b1;
                buf_addr_d = bus.tape_addr;
                buf_data_d = bus.tape_din;
            end else begin
                tape_ovf_d = 1'b1;
            end
        end
        if (tape_grant)
            starve_d = '0;
        else if (buf_vld_q && cpu_grant && starve_q != STARVE_MAX)
            starve_d = starve_q + STARVE_ONE;
        if (tape_grant && tape_count_q != CNT_MAX)
            tape_count_d = tape_count_q + CNT_ONE;
        if (bus.clr_start) begin
            tape_ovf_d   = 1'b0;
            tape_count_d = '0;
        end
        rd_pipe_d  = {rd_pipe_q[0], cpu_grant & ~bus.cpu_we};
        cpu_dout_d = rd_pipe_q[0] ? bus.mem_q : cpu_dout_q;
    end

    assign bus.clr_busy   = (state_q == ST_CLEAR);
    assign bus.cpu_wait   = bus.cpu_cs & ~cpu_grant;
    assign bus.cpu_rvalid = rd_pipe_q[1];
    assign bus.cpu_dout   = cpu_dout_q;
    assign bus.tape_wait  = buf_vld_q;
    assign bus.tape_ovf   = tape_ovf_q;
    assign bus.tape_count = tape_count_q;
endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Directed bench for oric_ram_arbiter with a small (AW=8) RAM so full clears stay short.
module tb_oric_ram_arbiter;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   bad;
    logic [4:0] wv;

    always #5 clk = ~clk;

    oric_ram_arbiter_if #(.AW(AW)) bus ();

    oric_ram_arbiter #(
        .AW(AW), .CLR_VAL(8'hFF), .CLR_ON_RESET(1'b1), .STARVE(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // synchronous RAM, read-before-write
    logic [7:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        bus.mem_q <= ram[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string tag, output int nowait);
        int n;
        n = 0;
        nowait = 0;
        while (bus.clr_busy && n < 1000) begin
            if (bus.cpu_cs && !bus.cpu_wait) nowait++;
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(n), 32'(DEPTH));
    endtask

    function automatic int count_not_ff();
        int c;
        c = 0;
        for (int a = 0; a < DEPTH; a++) if (ram[a] !== 8'hFF) c++;
        return c;
    endfunction

    initial begin
        reset_n       = 1'b0;
        bus.clr_start = 1'b0;
        bus.cpu_cs    = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_din   = '0;
        bus.tape_wr   = 1'b0;
        bus.tape_addr = '0;
        bus.tape_din  = '0;

        repeat (3) @(posedge clk);
        #4;
        chk("rst_busy",   32'(bus.clr_busy), 32'd1);
        chk("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst_dout",   32'(bus.cpu_dout), 32'd0);
        chk("rst_ovf",    32'(bus.tape_ovf), 32'd0);
        chk("rst_count",  32'(bus.tape_count), 32'd0);
        chk("rst_twait",  32'(bus.tape_wait), 32'd0);
        chk("rst_addr",   32'(bus.mem_addr), 32'd0);
        chk("rst_we",     32'(bus.mem_we), 32'd1);
        chk("rst_din",    32'(bus.mem_din), 32'hFF);

        // power-up clear with the CPU requesting throughout
        cyc();
        reset_n = 1'b1;
        wait_clear("clr_len", bad);
        chk("clr_cpu_wait", 32'(bad), 32'd0);
        bus.cpu_cs = 1'b0;
        chk("clr_fill", 32'(count_not_ff()), 32'd0);

        // CPU write then read back
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h40; bus.cpu_din = 8'h5A;
        #3;
        chk("wr_wait", 32'(bus.cpu_wait), 32'd0);
        chk("wr_we",   32'(bus.mem_we), 32'd1);
        chk("wr_addr", 32'(bus.mem_addr), 32'h40);
        chk("wr_din",  32'(bus.mem_din), 32'h5A);
        cyc();
        bus.cpu_we = 1'b0;
        #3;
        chk("rd_we",   32'(bus.mem_we), 32'd0);
        chk("rd_addr", 32'(bus.mem_addr), 32'h40);
        cyc();
        bus.cpu_cs = 1'b0;
        #3;
        chk("wr_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        cyc();
        #3;
        chk("rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("rd_dout",   32'(bus.cpu_dout), 32'h5A);
        cyc();
        #3;
        chk("rd_pulse_end", 32'(bus.cpu_rvalid), 32'd0);
        chk("rd_dout_hold", 32'(bus.cpu_dout), 32'h5A);
        chk("idle_addr",    32'(bus.mem_addr), 32'h40);
        chk("idle_we",      32'(bus.mem_we), 32'd0);

        // three tape bytes, CPU idle
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.tape_wr = 1'b1; bus.tape_addr = 8'(8'h50 + i); bus.tape_din = 8'(8'hA0 + i);
            #3;
            chk("tp_wait_pre", 32'(bus.tape_wait), 32'd0);
            cyc();
            bus.tape_wr = 1'b0;
            #3;
            chk("tp_we",   32'(bus.mem_we), 32'd1);
            chk("tp_addr", 32'(bus.mem_addr), 32'(8'h50 + i));
            chk("tp_din",  32'(bus.mem_din), 32'(8'hA0 + i));
        end
        cyc();
        #3;
        chk("tp_count", 32'(bus.tape_count), 32'd3);
        chk("tp_ovf",   32'(bus.tape_ovf), 32'd0);
        chk("tp_ram",   32'(ram[8'h51]), 32'hA1);

        // starvation: CPU reads continuously while the tape byte waits
        cyc();
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
        bus.tape_wr = 1'b1; bus.tape_addr = 8'h58; bus.tape_din = 8'hC5;
        cyc();
        bus.tape_wr = 1'b0;
        wv = '0;
        for (int k = 0; k < 5; k++) begin
            #3;
            wv[k] = bus.cpu_wait;
            if (k == 4) begin
                chk("st_we",   32'(bus.mem_we), 32'd1);
                chk("st_addr", 32'(bus.mem_addr), 32'h58);
                chk("st_din",  32'(bus.mem_din), 32'hC5);
            end
            cyc();
        end
        chk("st_wait_pat", 32'(wv), 32'b10000);
        #3;
        chk("st_after_wait", 32'(bus.cpu_wait), 32'd0);
        chk("st_ram",        32'(ram[8'h58]), 32'hC5);
        chk("st_count",      32'(bus.tape_count), 32'd4);

        // two back-to-back tape_wr while the CPU is busy: second is dropped
        cyc();
        bus.tape_wr = 1'b1; bus.tape_addr = 8'h60; bus.tape_din = 8'h11;
        cyc();
        bus.tape_addr = 8'h61; bus.tape_din = 8'h22;
        #3;
        chk("ovf_twait", 32'(bus.tape_wait), 32'd1);
        cyc();
        bus.tape_wr = 1'b0; bus.cpu_cs = 1'b0;
        #3;
        chk("ovf_flag", 32'(bus.tape_ovf), 32'd1);
        chk("ovf_addr", 32'(bus.mem_addr), 32'h60);
        chk("ovf_din",  32'(bus.mem_din), 32'h11);
        cyc();
        #3;
        chk("ovf_count",   32'(bus.tape_count), 32'd5);
        chk("ovf_ram0",    32'(ram[8'h60]), 32'h11);
        chk("ovf_dropped", 32'(ram[8'h61]), 32'hFF);

        // same-address CPU and tape write: tape byte lands last
        cyc();
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h70; bus.cpu_din = 8'h33;
        bus.tape_wr = 1'b1; bus.tape_addr = 8'h70; bus.tape_din = 8'h44;
        #3;
        chk("col_cpu_din", 32'(bus.mem_din), 32'h33);
        cyc();
        bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.tape_wr = 1'b0;
        #3;
        chk("col_tape_din", 32'(bus.mem_din), 32'h44);
        cyc();
        #3;
        chk("col_ram",   32'(ram[8'h70]), 32'h44);
        chk("col_count", 32'(bus.tape_count), 32'd6);

        // clr_start, then restart mid-clear at the halfway point
        bus.clr_start = 1'b1;
        cyc();
        bus.clr_start = 1'b0;
        #3;
        chk("cs_busy",  32'(bus.clr_busy), 32'd1);
        chk("cs_count", 32'(bus.tape_count), 32'd0);
        chk("cs_ovf",   32'(bus.tape_ovf), 32'd0);
        repeat (128) cyc();
        #3;
        chk("cs_half_ptr", 32'(bus.mem_addr), 32'h80);
        bus.clr_start = 1'b1;
        cyc();
        bus.clr_start = 1'b0;
        #3;
        chk("cs_restart_ptr", 32'(bus.mem_addr), 32'd0);
        wait_clear("cs_restart_len", bad);
        chk("cs_fill", 32'(count_not_ff()), 32'd0);

        // reset mid-read with a buffered tape byte: both are lost
        bus.cpu_cs = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h40;
        bus.tape_wr = 1'b1; bus.tape_addr = 8'h77; bus.tape_din = 8'h99;
        cyc();
        bus.cpu_cs = 1'b0; bus.tape_wr = 1'b0;
        reset_n = 1'b0;
        #3;
        chk("ab_twait", 32'(bus.tape_wait), 32'd0);
        chk("ab_busy",  32'(bus.clr_busy), 32'd1);
        cyc();
        #3;
        chk("ab_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("ab_dout",   32'(bus.cpu_dout), 32'd0);
        cyc();
        reset_n = 1'b1;
        wait_clear("ab_clr_len", bad);
        chk("ab_ram", 32'(ram[8'h77]), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
